// File: rtl/msi_cfg_pkg.sv
// Shared definitions for the MSI001 configuration sequencer: FSM states,
// word layout, register addresses and the power-up init table.
package msi_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned PAYLOAD_W = 20;
  localparam int unsigned WORD_W    = 24;

  localparam logic [ADDR_W-1:0] REG0 = 4'd0;
  localparam logic [ADDR_W-1:0] REG1 = 4'd1;
  localparam logic [ADDR_W-1:0] REG2 = 4'd2;
  localparam logic [ADDR_W-1:0] REG3 = 4'd3;
  localparam logic [ADDR_W-1:0] REG4 = 4'd4;
  localparam logic [ADDR_W-1:0] REG5 = 4'd5;
  localparam logic [ADDR_W-1:0] REG6 = 4'd6;

  // Words are {payload, addr}; the transmitter shifts them out LSB-nibble first.
  function automatic logic [WORD_W-1:0] init_word(input logic [2:0] idx);
    logic [WORD_W-1:0] w;
    case (idx)
      3'd0:    w = {20'h43420, REG0};
      3'd1:    w = {20'h0A501, REG1};
      3'd2:    w = {20'h01E85, REG2};
      3'd3:    w = {20'h00000, REG3};
      3'd4:    w = {20'h2B3A8, REG5};
      3'd5:    w = {20'h00000, REG6};
      3'd6:    w = {20'h00000, REG4};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/msi_cfg_rom.sv
// Combinational lookup of the init table: 3-bit index to 24-bit MSI001 word.
module msi_cfg_rom
  import msi_cfg_pkg::*;
(
  input  logic [2:0]        idx,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = init_word(idx);
  end

endmodule

// File: rtl/msi_cfg_sequencer.sv
// Feeds the MSI001 SPI transmitter: walks the init table, then services tune
// writes, spacing SPI_tx_en strobes exactly WORD_GAP cycles apart.
module msi_cfg_sequencer
  import msi_cfg_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 6,
  parameter int unsigned WORD_GAP  = 15100,
  parameter int unsigned GAP_W     = 14,
  parameter bit          AUTO_INIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 init_start,
  input  logic                 tune_req,
  input  logic [ADDR_W-1:0]    tune_addr,
  input  logic [PAYLOAD_W-1:0] tune_data,
  output logic [WORD_W-1:0]    data,
  output logic                 SPI_tx_en,
  output logic                 busy,
  output logic                 init_done,
  output logic                 tune_ovf
);

  state_t             state, state_d;
  logic [GAP_W-1:0]   cnt, cnt_d;
  logic [2:0]         idx, idx_d;
  logic               in_init, in_init_d;
  logic               auto_arm, auto_arm_d;
  logic               pend_valid, pend_valid_d;
  logic [WORD_W-1:0]  pend_word, pend_word_d;
  logic [WORD_W-1:0]  tune_hold, tune_hold_d;
  logic [WORD_W-1:0]  data_d;
  logic               tx_en_d, busy_d, init_done_d, ovf_d;
  logic [WORD_W-1:0]  rom_word;
  logic [WORD_W-1:0]  tune_word;
  logic               gap_end;
  logic               more_words;

  msi_cfg_rom u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  assign tune_word  = {tune_data, tune_addr};
  assign gap_end    = (state == GAP) && (cnt == GAP_W'(WORD_GAP - 1));
  assign more_words = in_init && (idx < 3'(NUM_WORDS - 1));

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    in_init_d    = in_init;
    auto_arm_d   = auto_arm;
    pend_valid_d = pend_valid;
    pend_word_d  = pend_word;
    tune_hold_d  = tune_hold;
    data_d       = data;
    tx_en_d      = 1'b0;
    init_done_d  = init_done;
    ovf_d        = 1'b0;

    unique case (state)
      IDLE: begin
        if (init_start || auto_arm) begin
          state_d     = EMIT;
          idx_d       = '0;
          in_init_d   = 1'b1;
          init_done_d = 1'b0;
          auto_arm_d  = 1'b0;
          if (tune_req) begin
            pend_valid_d = 1'b1;
            pend_word_d  = tune_word;
          end
        end else if (tune_req) begin
          state_d     = EMIT;
          in_init_d   = 1'b0;
          tune_hold_d = tune_word;
        end
      end
      EMIT: begin
        state_d = GAP;
        data_d  = in_init ? rom_word : tune_hold;
        tx_en_d = 1'b1;
        cnt_d   = GAP_W'(1);
      end
      GAP: begin
        if (gap_end) begin
          cnt_d = '0;
          if (more_words) begin
            idx_d   = idx + 3'd1;
            state_d = EMIT;
          end else begin
            if (in_init) begin
              init_done_d = 1'b1;
              in_init_d   = 1'b0;
            end
            if (pend_valid) begin
              tune_hold_d  = pend_word;
              pend_valid_d = 1'b0;
              state_d      = EMIT;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Testing the post-consume slot state lets a request land in the same
    // cycle the pending word is handed to EMIT.
    if ((state != IDLE) && tune_req) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_word_d  = tune_word;
      end else begin
        ovf_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      in_init    <= 1'b0;
      auto_arm   <= AUTO_INIT;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      tune_hold  <= '0;
      data       <= '0;
      SPI_tx_en  <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      tune_ovf   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      in_init    <= in_init_d;
      auto_arm   <= auto_arm_d;
      pend_valid <= pend_valid_d;
      pend_word  <= pend_word_d;
      tune_hold  <= tune_hold_d;
      data       <= data_d;
      SPI_tx_en  <= tx_en_d;
      busy       <= busy_d;
      init_done  <= init_done_d;
      tune_ovf   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_msi_cfg_sequencer.sv
// Directed bench for msi_cfg_sequencer: one auto-init instance and one
// manual-start instance, both with a 16-cycle word gap.
module tb_msi_cfg_sequencer;

  localparam logic [23:0] TBL [6] = '{24'h434200, 24'h0A5011, 24'h01E852,
                                      24'h000003, 24'h2B3A85, 24'h000006};

  logic        clk = 1'b0;
  logic        a_rst, b_rst, a_start, b_start, a_treq, b_treq;
  logic [3:0]  t_addr;
  logic [19:0] t_data;
  logic [23:0] a_data, b_data;
  logic        a_tx, b_tx, a_busy, b_busy, a_done, b_done, a_ovf, b_ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base, s0;
  int a_strb = 0, b_strb = 0;
  logic a_prev = 1'b0, b_prev = 1'b0, a_b2b = 1'b0, b_b2b = 1'b0;

  always #5 clk = ~clk;

  msi_cfg_sequencer #(.NUM_WORDS(6), .WORD_GAP(16), .GAP_W(5), .AUTO_INIT(1'b1)) dut_a (
    .clk(clk), .RST(a_rst), .init_start(a_start), .tune_req(a_treq),
    .tune_addr(t_addr), .tune_data(t_data), .data(a_data), .SPI_tx_en(a_tx),
    .busy(a_busy), .init_done(a_done), .tune_ovf(a_ovf));

  msi_cfg_sequencer #(.NUM_WORDS(6), .WORD_GAP(16), .GAP_W(5), .AUTO_INIT(1'b0)) dut_b (
    .clk(clk), .RST(b_rst), .init_start(b_start), .tune_req(b_treq),
    .tune_addr(t_addr), .tune_data(t_data), .data(b_data), .SPI_tx_en(b_tx),
    .busy(b_busy), .init_done(b_done), .tune_ovf(b_ovf));

  always @(negedge clk) begin
    if (a_tx) a_strb++;
    if (b_tx) b_strb++;
    if (a_tx && a_prev) a_b2b = 1'b1;
    if (b_tx && b_prev) b_b2b = 1'b1;
    a_prev = a_tx;
    b_prev = b_tx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic at(input int c);
    if (c > cyc) adv(c - cyc);
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; a_treq = 1'b0; b_treq = 1'b0;
    t_addr = '0; t_data = '0;
    adv(3);
    chk("rst a_data", a_data, 24'h0);
    chk("rst a_tx", a_tx, 1'b0);
    chk("rst a_busy", a_busy, 1'b0);
    chk("rst a_done", a_done, 1'b0);
    chk("rst a_ovf", a_ovf, 1'b0);
    chk("rst b_data", b_data, 24'h0);
    chk("rst b_busy", b_busy, 1'b0);

    // A1: auto init after release; cycle 0 is the first edge with RST low
    s0 = a_strb;
    a_rst = 1'b0;
    base = cyc + 1;
    at(base);
    chk("A1 busy c0", a_busy, 1'b1);
    chk("A1 tx c0", a_tx, 1'b0);
    for (int k = 0; k < 6; k++) begin
      at(base + 1 + 16 * k);
      chk($sformatf("A1 tx w%0d", k), a_tx, 1'b1);
      chk($sformatf("A1 data w%0d", k), a_data, TBL[k]);
      at(base + 2 + 16 * k);
      chk($sformatf("A1 tx off w%0d", k), a_tx, 1'b0);
      chk($sformatf("A1 hold w%0d", k), a_data, TBL[k]);
    end
    at(base + 95);
    chk("A1 busy c95", a_busy, 1'b1);
    chk("A1 done c95", a_done, 1'b0);
    at(base + 96);
    chk("A1 busy c96", a_busy, 1'b0);
    chk("A1 done c96", a_done, 1'b1);
    at(base + 130);
    chk("A1 strobes", a_strb - s0, 6);

    // A2: tune queued during init, second one overflows
    a_rst = 1'b1;
    adv(1);
    s0 = a_strb;
    a_rst = 1'b0;
    base = cyc + 1;
    at(base + 33);
    t_addr = 4'h2; t_data = 20'h00012; a_treq = 1'b1;
    adv(1);
    a_treq = 1'b0;
    chk("A2 no ovf", a_ovf, 1'b0);
    at(base + 40);
    t_addr = 4'h7; t_data = 20'hFFFFF; a_treq = 1'b1;
    adv(1);
    a_treq = 1'b0;
    chk("A2 ovf pulse", a_ovf, 1'b1);
    adv(1);
    chk("A2 ovf clear", a_ovf, 1'b0);
    at(base + 96);
    chk("A2 done c96", a_done, 1'b1);
    chk("A2 busy c96", a_busy, 1'b1);
    at(base + 97);
    chk("A2 tx w6", a_tx, 1'b1);
    chk("A2 data w6", a_data, 24'h000122);
    at(base + 112);
    chk("A2 busy end", a_busy, 1'b0);
    at(base + 120);
    chk("A2 strobes", a_strb - s0, 7);
    chk("A2 hold", a_data, 24'h000122);

    // A3: one-cycle reset in the gap after word 3 drops pending and restarts
    a_rst = 1'b1;
    adv(1);
    s0 = a_strb;
    a_rst = 1'b0;
    base = cyc + 1;
    at(base + 20);
    t_addr = 4'h9; t_data = 20'h00001; a_treq = 1'b1;
    adv(1);
    a_treq = 1'b0;
    at(base + 49);
    chk("A3 data w3", a_data, TBL[3]);
    at(base + 55);
    a_rst = 1'b1;
    adv(1);
    chk("A3 rst data", a_data, 24'h0);
    chk("A3 rst tx", a_tx, 1'b0);
    chk("A3 rst busy", a_busy, 1'b0);
    chk("A3 rst ovf", a_ovf, 1'b0);
    a_rst = 1'b0;
    base = cyc + 1;
    at(base + 1);
    chk("A3 restart tx", a_tx, 1'b1);
    chk("A3 restart data", a_data, TBL[0]);
    at(base + 96);
    chk("A3 busy end", a_busy, 1'b0);
    chk("A3 done", a_done, 1'b1);
    at(base + 110);
    chk("A3 strobes", a_strb - s0, 10);

    // B1: no auto init; single tune write from IDLE
    s0 = b_strb;
    b_rst = 1'b0;
    adv(5);
    chk("B1 idle busy", b_busy, 1'b0);
    chk("B1 idle strobes", b_strb - s0, 0);
    t_addr = 4'h1; t_data = 20'hABCDE; b_treq = 1'b1;
    adv(1);
    b_treq = 1'b0;
    base = cyc;
    chk("B1 busy T", b_busy, 1'b1);
    chk("B1 tx T", b_tx, 1'b0);
    at(base + 1);
    chk("B1 tx T+1", b_tx, 1'b1);
    chk("B1 data", b_data, 24'hABCDE1);
    at(base + 2);
    chk("B1 tx T+2", b_tx, 1'b0);
    at(base + 15);
    chk("B1 busy T+15", b_busy, 1'b1);
    at(base + 16);
    chk("B1 busy T+16", b_busy, 1'b0);
    chk("B1 done", b_done, 1'b0);

    // B2: init_start and tune_req together; init_start mid-run is ignored
    adv(2);
    t_addr = 4'h3; t_data = 20'h5A5A5; b_start = 1'b1; b_treq = 1'b1;
    adv(1);
    b_start = 1'b0; b_treq = 1'b0;
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      at(base + 1 + 16 * k);
      chk($sformatf("B2 tx w%0d", k), b_tx, 1'b1);
      chk($sformatf("B2 data w%0d", k), b_data, TBL[k]);
      if (k == 2) begin
        at(base + 40);
        b_start = 1'b1;
        adv(1);
        b_start = 1'b0;
      end
    end
    at(base + 96);
    chk("B2 done", b_done, 1'b1);
    at(base + 97);
    chk("B2 tx tune", b_tx, 1'b1);
    chk("B2 data tune", b_data, 24'h5A5A53);
    at(base + 112);
    chk("B2 busy end", b_busy, 1'b0);

    // B3: tune write leaves init_done set
    adv(2);
    t_addr = 4'hF; t_data = 20'h00001; b_treq = 1'b1;
    adv(1);
    b_treq = 1'b0;
    base = cyc;
    chk("B3 done kept", b_done, 1'b1);
    at(base + 1);
    chk("B3 data", b_data, 24'h00001F);
    at(base + 16);
    chk("B3 busy end", b_busy, 1'b0);
    chk("B3 done end", b_done, 1'b1);

    // B4: init_start alone clears init_done and restarts the table
    adv(1);
    b_start = 1'b1;
    adv(1);
    b_start = 1'b0;
    base = cyc;
    chk("B4 done clr", b_done, 1'b0);
    chk("B4 busy", b_busy, 1'b1);
    at(base + 1);
    chk("B4 data w0", b_data, TBL[0]);

    chk("A back-to-back", a_b2b, 1'b0);
    chk("B back-to-back", b_b2b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
